pipe_delay_ring: RTL and testbench
==================================

// Module: pipe_delay_ring
// PURPOSE
//  Pipeline delay buffer driven by the pipe start FSM: a circular simple-dual-port RAM holding ADC samples.
//  Consumes WE/RE/PIP_RST/INC_H from the FSM and returns HOLD (hold counter) and WCNT (occupancy) to it.
//  Once WCNT reaches PDEPTH the FSM asserts RE and WE together, giving a fixed delay of PDEPTH samples.
//  Sits between the ADC deserialiser (DIN) and the L1A sample-capture logic (DOUT/DV).
// PARAMETERS
//  DW     72  data width (6 channels x 12-bit samples)
//  AW     9   address width; depth 2**AW = 512, matching the 9-bit PDEPTH/WCNT
//  HW     4   hold counter width
// PORTS
//  CLK      in   1    sample clock
//  RST      in   1    synchronous, active-high reset
//  INC_H    in   1    advance hold counter (from FSM)
//  PIP_RST  in   1    pipeline reset: clear pointers, occupancy, flags
//  WE       in   1    write DIN at write pointer
//  RE       in   1    read at read pointer
//  DIN      in   DW   input sample word
//  HOLD     out  HW   hold counter (to FSM)
//  WCNT     out  AW   occupancy, written-minus-read (to FSM)
//  DOUT     out  DW   delayed sample word, registered
//  DV       out  1    DOUT valid; RE delayed one cycle
//  OVFL     out  1    sticky overflow flag
//  UNFL     out  1    sticky underflow flag
// BEHAVIOUR
//  Reset (RST=1 at a CLK edge): HOLD=0, WCNT=0, DOUT=0, DV=0, OVFL=0, UNFL=0, wptr=rptr=0.
//  - RAM contents are not cleared.
//  - RST has priority over every other input.
//  HOLD: INC_H=1 -> HOLD+1, wrapping 15->0; INC_H=0 -> HOLD=0 on the next edge.
//  - Successive FSM stages therefore see HOLD values 5, 10 and 15 without reloading.
//  PIP_RST=1: same effect as RST except HOLD, which follows INC_H as usual.
//  - WE/RE in the same cycle are ignored: no write, no read, DV=0 next cycle.
//  Write: WE=1 and not full -> RAM[wptr]<=DIN; wptr+1, wrapping 2**AW-1 -> 0.
//  Read: RE=1 and not empty -> DOUT<=RAM[rptr] on the next edge, DV=1; rptr+1, wrapping.
//  - Read latency is 1 cycle.
//  WCNT update:
//  - WE only: +1.
//  - RE only: -1.
//  - Both, or neither: hold.
//  - Only accepted operations count.
//  Full = (WCNT == 2**AW-1): one slot is kept free so the pointers never alias.
//  - A WE while full is dropped: no write, wptr unchanged, OVFL<=1.
//  - Exception: full with WE and RE together -> both proceed and WCNT holds.
//  Empty = (WCNT == 0): a RE while empty does not advance rptr; DV=0, DOUT holds, UNFL<=1.
//  - Exception: empty with WE and RE together -> write is accepted, read is rejected, WCNT+1, UNFL<=1.
//  Read-during-write to the same address returns the OLD data; this cannot arise when WCNT>0.
//  OVFL/UNFL clear only on RST or PIP_RST.
//  No state machine; the control is pointer/counter only.
// STRUCTURE
//  Package pipe_pkg: DW, AW, HW defaults; FULL_CNT = 2**AW-1.
//  Sub-module pipe_dpram: simple dual-port RAM, one write port and one registered read port.
//  - Single clock, no reset; infers block RAM.
//  The top level holds the pointers, occupancy counter, hold counter and flags.
// TESTING
//  1. RST mid-run (WCNT=37, HOLD=6) -> next cycle all outputs 0, wptr=rptr=0.
//  2. INC_H high 17 cycles -> HOLD 1..15, 0, 1; drop INC_H -> HOLD=0 next edge.
//  3. PIP_RST, then WE for 100 cycles with DIN=k -> WCNT=100.
//     Then WE+RE continuously -> DOUT=k-100 with DV one cycle after each RE; WCNT stays 100.
//  4. WE-only for 520 cycles -> WCNT stops at 511.
//     OVFL=1 from write 512 onward; RAM data 0..510 is read back intact.
//  5. RE on empty -> UNFL=1, DV=0, WCNT=0.
//     WE+RE on empty -> WCNT=1 and the written data is read correctly next.
//  6. Pointer wrap: WE+RE with WCNT=200 for 1500 cycles -> delay constant at 200 across rptr/wptr wrap.

Source files
------------

// File: rtl/pipe_delay_ring_pkg.sv
// Shared sizing for the pipeline delay ring: sample width, RAM address width,
// hold counter width and the occupancy level treated as full.
package pipe_pkg;

  localparam int PIPE_DW  = 72;
  localparam int PIPE_AW  = 9;
  localparam int PIPE_HW  = 4;
  localparam int FULL_CNT = 2**PIPE_AW - 1;

endpackage

// File: rtl/pipe_delay_ring_if.sv
// Control/data bundle between the pipe start FSM (master) and the delay ring (slave).
interface pipe_delay_ring_if
  import pipe_pkg::*;
#(
  parameter int DW = PIPE_DW,
  parameter int AW = PIPE_AW,
  parameter int HW = PIPE_HW
) ();

  logic          INC_H;
  logic          PIP_RST;
  logic          WE;
  logic          RE;
  logic [DW-1:0] DIN;
  logic [HW-1:0] HOLD;
  logic [AW-1:0] WCNT;
  logic [DW-1:0] DOUT;
  logic          DV;
  logic          OVFL;
  logic          UNFL;

  modport master (
    output INC_H, PIP_RST, WE, RE, DIN,
    input  HOLD, WCNT, DOUT, DV, OVFL, UNFL
  );

  modport slave (
    input  INC_H, PIP_RST, WE, RE, DIN,
    output HOLD, WCNT, DOUT, DV, OVFL, UNFL
  );

endinterface

// File: rtl/pipe_delay_ring_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// No reset so that it maps onto block RAM; a same-address read returns old data.
module pipe_dpram
#(
  parameter int DW = 72,
  parameter int AW = 9
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge CLK) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipe_delay_ring.sv
// Circular delay buffer for ADC samples: pointers, occupancy, hold counter and
// sticky flags around a dual-port RAM, controlled by the pipe start FSM.
module pipe_delay_ring
  import pipe_pkg::*;
#(
  parameter int DW = PIPE_DW,
  parameter int AW = PIPE_AW,
  parameter int HW = PIPE_HW
) (
  input  logic           CLK,
  input  logic           RST,
  pipe_delay_ring_if.slave bus
);

  localparam logic [AW-1:0] FULL_LVL = '1;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] wcnt;
  logic [HW-1:0] hold;
  logic          dv;
  logic          ovfl;
  logic          unfl;
  logic          dout_clr;
  logic [DW-1:0] rdata;
  logic          active;
  logic          full;
  logic          empty;
  logic          wr_ok;
  logic          rd_ok;

  // A full ring still accepts a write when a read frees a slot in the same cycle.
  assign active = !RST && !bus.PIP_RST;
  assign full   = (wcnt == FULL_LVL);
  assign empty  = (wcnt == '0);
  assign wr_ok  = active && bus.WE && (!full || bus.RE);
  assign rd_ok  = active && bus.RE && !empty;

  pipe_dpram #(.DW(DW), .AW(AW)) u_ram (
    .CLK   (CLK),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (bus.DIN),
    .re    (rd_ok),
    .raddr (rptr),
    .rdata (rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST)
      hold <= '0;
    else if (bus.INC_H)
      hold <= hold + 1'b1;
    else
      hold <= '0;
  end

  // The RAM read register has no reset, so DOUT is masked until the next accepted read.
  always_ff @(posedge CLK) begin
    if (RST || bus.PIP_RST) begin
      wptr     <= '0;
      rptr     <= '0;
      wcnt     <= '0;
      dv       <= 1'b0;
      ovfl     <= 1'b0;
      unfl     <= 1'b0;
      dout_clr <= 1'b1;
    end else begin
      if (wr_ok)
        wptr <= wptr + 1'b1;
      if (rd_ok) begin
        rptr     <= rptr + 1'b1;
        dout_clr <= 1'b0;
      end
      dv <= rd_ok;
      case ({wr_ok, rd_ok})
        2'b10:   wcnt <= wcnt + 1'b1;
        2'b01:   wcnt <= wcnt - 1'b1;
        default: wcnt <= wcnt;
      endcase
      if (bus.WE && full && !bus.RE)
        ovfl <= 1'b1;
      if (bus.RE && empty)
        unfl <= 1'b1;
    end
  end

  assign bus.HOLD = hold;
  assign bus.WCNT = wcnt;
  assign bus.DOUT = dout_clr ? '0 : rdata;
  assign bus.DV   = dv;
  assign bus.OVFL = ovfl;
  assign bus.UNFL = unfl;

endmodule

// File: tb/tb_pipe_delay_ring.sv
// Self-checking bench for pipe_delay_ring: directed vector table, directed
// sequences and randomized traffic against a queue-based reference model.
module tb_pipe_delay_ring;
  import pipe_pkg::*;

  logic CLK;
  logic RST;

  pipe_delay_ring_if bus ();

  pipe_delay_ring dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        pip;
    logic        inc;
    logic        we;
    logic        re;
    logic [71:0] din;
    logic [3:0]  hold;
    logic [8:0]  wcnt;
    logic        dv;
    logic [71:0] dout;
    logic        ovfl;
    logic        unfl;
  } vec_t;

  vec_t vecs [10];

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: the ring is just a FIFO queue of samples.
  logic [71:0] mq [$];
  int          m_hold;
  logic [71:0] m_dout;
  logic        m_dv;
  logic        m_ovfl;
  logic        m_unfl;

  function automatic logic [71:0] rnd72();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[71:0];
  endfunction

  task automatic modelStep(input logic rst, input logic pip, input logic inc,
                           input logic we, input logic re, input logic [71:0] din);
    bit rd;
    bit wr;
    if (rst) begin
      mq.delete();
      m_hold = 0;
      m_dout = '0;
      m_dv   = 1'b0;
      m_ovfl = 1'b0;
      m_unfl = 1'b0;
      return;
    end
    m_hold = inc ? (m_hold + 1) % 16 : 0;
    if (pip) begin
      mq.delete();
      m_dout = '0;
      m_dv   = 1'b0;
      m_ovfl = 1'b0;
      m_unfl = 1'b0;
      return;
    end
    rd = re && (mq.size() > 0);
    wr = we && ((mq.size() < FULL_CNT) || re);
    if (we && mq.size() == FULL_CNT && !re) m_ovfl = 1'b1;
    if (re && mq.size() == 0) m_unfl = 1'b1;
    if (rd) begin
      m_dout = mq.pop_front();
      m_dv   = 1'b1;
    end else begin
      m_dv = 1'b0;
    end
    if (wr) mq.push_back(din);
  endtask

  task automatic applyStimulus(input logic rst, input logic pip, input logic inc,
                               input logic we, input logic re, input logic [71:0] din);
    RST         = rst;
    bus.PIP_RST = pip;
    bus.INC_H   = inc;
    bus.WE      = we;
    bus.RE      = re;
    bus.DIN     = din;
    modelStep(rst, pip, inc, we, re, din);
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    bit bad;
    bad = 0;
    if (bus.HOLD !== 4'(m_hold)) begin
      $display("[TB] FAIL %s HOLD got %0d expected %0d", tag, bus.HOLD, m_hold); bad = 1;
    end
    if (bus.WCNT !== 9'(mq.size())) begin
      $display("[TB] FAIL %s WCNT got %0d expected %0d", tag, bus.WCNT, mq.size()); bad = 1;
    end
    if (bus.DV !== m_dv) begin
      $display("[TB] FAIL %s DV got %b expected %b", tag, bus.DV, m_dv); bad = 1;
    end
    if (bus.DOUT !== m_dout) begin
      $display("[TB] FAIL %s DOUT got %h expected %h", tag, bus.DOUT, m_dout); bad = 1;
    end
    if (bus.OVFL !== m_ovfl) begin
      $display("[TB] FAIL %s OVFL got %b expected %b", tag, bus.OVFL, m_ovfl); bad = 1;
    end
    if (bus.UNFL !== m_unfl) begin
      $display("[TB] FAIL %s UNFL got %b expected %b", tag, bus.UNFL, m_unfl); bad = 1;
    end
    vectors++;
    if (bad) miscompares++;
  endtask

  task automatic checkVal(input string tag, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic pip, input logic inc,
                      input logic we, input logic re, input logic [71:0] din);
    applyStimulus(rst, pip, inc, we, re, din);
    checkOutput(tag);
  endtask

  initial begin
    RST = 1'b1; bus.PIP_RST = 1'b0; bus.INC_H = 1'b0;
    bus.WE = 1'b0; bus.RE = 1'b0; bus.DIN = '0;

    //           rst   pip   inc   we    re    din       hold  wcnt  dv    dout      ovfl  unfl
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 72'h0,  4'd0, 9'd0, 1'b0, 72'h0,  1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 72'hA,  4'd0, 9'd1, 1'b0, 72'h0,  1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 72'hB,  4'd1, 9'd2, 1'b0, 72'h0,  1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 72'h0,  4'd2, 9'd1, 1'b1, 72'hA,  1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 72'h0,  4'd0, 9'd0, 1'b1, 72'hB,  1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 72'h0,  4'd0, 9'd0, 1'b0, 72'hB,  1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 72'hC,  4'd0, 9'd1, 1'b0, 72'hB,  1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 72'h0,  4'd0, 9'd0, 1'b1, 72'hC,  1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 72'hD,  4'd1, 9'd0, 1'b0, 72'h0,  1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 72'hE,  4'd2, 9'd1, 1'b0, 72'h0,  1'b0, 1'b1};

    @(posedge CLK); #1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].pip, vecs[i].inc, vecs[i].we, vecs[i].re, vecs[i].din);
      checkVal($sformatf("tbl%0d_hold", i), 72'(bus.HOLD), 72'(vecs[i].hold));
      checkVal($sformatf("tbl%0d_wcnt", i), 72'(bus.WCNT), 72'(vecs[i].wcnt));
      checkVal($sformatf("tbl%0d_dv",   i), 72'(bus.DV),   72'(vecs[i].dv));
      checkVal($sformatf("tbl%0d_dout", i), bus.DOUT,      vecs[i].dout);
      checkVal($sformatf("tbl%0d_ovfl", i), 72'(bus.OVFL), 72'(vecs[i].ovfl));
      checkVal($sformatf("tbl%0d_unfl", i), 72'(bus.UNFL), 72'(vecs[i].unfl));
      checkOutput($sformatf("tbl%0d_model", i));
    end

    // RST in the middle of a run with WCNT=37, HOLD=6
    step("t1_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 72'h0);
    for (int i = 0; i < 37; i++)
      step("t1_fill", 1'b0, 1'b0, (i >= 31) ? 1'b1 : 1'b0, 1'b1, 1'b0, 72'(i + 1));
    checkVal("t1_wcnt37", 72'(bus.WCNT), 72'd37);
    checkVal("t1_hold6", 72'(bus.HOLD), 72'd6);
    step("t1_midrst", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 72'h99);
    checkVal("t1_wcnt0", 72'(bus.WCNT), 72'd0);
    checkVal("t1_hold0", 72'(bus.HOLD), 72'd0);
    step("t1_rd_after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 72'h0);
    checkVal("t1_unfl_empty", 72'(bus.UNFL), 72'd1);

    // Hold counter wrap
    for (int i = 0; i < 17; i++) begin
      step("t2_inc", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 72'h0);
      checkVal($sformatf("t2_hold%0d", i), 72'(bus.HOLD), 72'((i + 1) % 16));
    end
    step("t2_drop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 72'h0);
    checkVal("t2_hold_clr", 72'(bus.HOLD), 72'd0);

    // Fixed delay of 100 samples
    step("t3_pip", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 72'h0);
    for (int k = 0; k < 100; k++)
      step("t3_fill", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 72'(k));
    checkVal("t3_wcnt100", 72'(bus.WCNT), 72'd100);
    for (int k = 100; k < 300; k++) begin
      step("t3_pipe", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 72'(k));
      checkVal("t3_delay", bus.DOUT, 72'(k - 100));
      checkVal("t3_dv", 72'(bus.DV), 72'd1);
      checkVal("t3_wcnt", 72'(bus.WCNT), 72'd100);
    end

    // Overflow: 520 writes, count saturates at 511, data 0..510 intact
    step("t4_pip", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 72'h0);
    for (int i = 0; i < 520; i++) begin
      step("t4_fill", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 72'(i));
      checkVal("t4_wcnt", 72'(bus.WCNT), 72'((i < 511) ? i + 1 : 511));
      checkVal("t4_ovfl", 72'(bus.OVFL), 72'((i >= 511) ? 1 : 0));
    end
    for (int i = 0; i < 511; i++) begin
      step("t4_drain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 72'h0);
      checkVal("t4_data", bus.DOUT, 72'(i));
    end
    checkVal("t4_empty", 72'(bus.WCNT), 72'd0);

    // Underflow and write+read on empty
    step("t5_pip", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 72'h0);
    step("t5_re_empty", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 72'h0);
    checkVal("t5_unfl", 72'(bus.UNFL), 72'd1);
    checkVal("t5_dv0", 72'(bus.DV), 72'd0);
    step("t5_wr_rd_empty", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 72'h55);
    checkVal("t5_wcnt1", 72'(bus.WCNT), 72'd1);
    step("t5_readback", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 72'h0);
    checkVal("t5_data", bus.DOUT, 72'h55);

    // Pointer wrap at constant delay 200
    step("t6_pip", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 72'h0);
    for (int i = 0; i < 200; i++)
      step("t6_fill", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rnd72());
    for (int i = 0; i < 1500; i++) begin
      step("t6_wrap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, rnd72());
      if (i % 100 == 0) checkVal("t6_wcnt", 72'(bus.WCNT), 72'd200);
    end

    // Random traffic with phases biased toward filling and draining
    for (int i = 0; i < 3000; i++) begin
      int wp;
      int rp;
      wp = ((i / 600) % 2 == 0) ? 85 : 30;
      rp = ((i / 600) % 2 == 0) ? 30 : 85;
      step("rand",
           ($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < rp) ? 1'b1 : 1'b0,
           rnd72());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
